// File: rtl/ddr_addr_pkg.sv
// Shared DDR frame-store addressing definitions for the read- and write-side address generators.
package ddr_addr_pkg;

  localparam int unsigned ADDR_WIDTH = 28;
  localparam int unsigned BUF_NUM    = 3;
  localparam int unsigned BUF_IDX_W  = 2;
  localparam int unsigned BEAT_BYTES = 32;

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR  = 28'h000_0000;
  localparam logic [ADDR_WIDTH-1:0] BUF_STRIDE = 28'h080_0000;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIssue
  } addr_state_e;

  // Start byte address of a frame buffer; wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic [BUF_IDX_W-1:0]  idx,
                                                     input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [ADDR_WIDTH-1:0] stride);
    return base + ADDR_WIDTH'(idx) * stride;
  endfunction

endpackage

// File: rtl/rd_buf_sel.sv
// Read-buffer selection: picks the buffer written just before the current write buffer,
// holding the previous choice when the resynchronised write index is out of range.
module rd_buf_sel #(
  parameter int unsigned BUF_NUM   = 3,
  parameter int unsigned BUF_IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BUF_IDX_W-1:0] wr_buf_idx,
  output logic [BUF_IDX_W-1:0] cur_buf_idx
);

  logic [BUF_IDX_W-1:0] sel_d, sel_q;

  always_comb begin
    sel_d = sel_q;
    if (load && (32'(wr_buf_idx) < BUF_NUM)) begin
      sel_d = (wr_buf_idx == '0) ? BUF_IDX_W'(BUF_NUM - 1) : wr_buf_idx - BUF_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= BUF_IDX_W'(BUF_NUM - 1);
    end else begin
      sel_q <= sel_d;
    end
  end

  assign cur_buf_idx = sel_q;

endmodule

// File: rtl/rd_frame_addr_gen.sv
// Read-side frame address generator: on each frame start, issues burst read commands covering
// the most recently completed buffer over a valid/ready command interface.
module rd_frame_addr_gen #(
  parameter int unsigned            ADDR_WIDTH  = 28,
  parameter int unsigned            BUF_NUM     = 3,
  parameter int unsigned            BUF_IDX_W   = 2,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 28'h000_0000,
  parameter logic [ADDR_WIDTH-1:0]  BUF_STRIDE  = 28'h080_0000,
  parameter int unsigned            FRAME_BEATS = 57600,
  parameter int unsigned            BURST_LEN   = 64,
  parameter int unsigned            BEAT_BYTES  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUF_IDX_W-1:0]  wr_buf_idx,
  input  logic                  frame_start,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic [BUF_IDX_W-1:0]  cur_buf_idx,
  output logic                  busy,
  output logic                  frame_done
);

  import ddr_addr_pkg::*;

  localparam int unsigned BEAT_W = $clog2(FRAME_BEATS + 1);

  function automatic logic [7:0] len_of(input logic [BEAT_W-1:0] beats);
    int unsigned b;
    b = 32'(beats);
    if (b > BURST_LEN) b = BURST_LEN;
    return 8'(b - 1);
  endfunction

  addr_state_e           state_d, state_q;
  logic [BEAT_W-1:0]     beats_left_d, beats_left_q;
  logic                  cmd_valid_d, cmd_valid_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_d, cmd_addr_q;
  logic [7:0]            cmd_len_d, cmd_len_q;
  logic                  busy_d, busy_q;
  logic                  frame_done_d, frame_done_q;
  logic                  restart_pend_d, restart_pend_q;

  logic        hs;
  logic        last;
  logic        sel_load;
  logic [31:0] beats_next;

  assign hs         = cmd_valid_q && cmd_ready;
  assign beats_next = 32'(beats_left_q) - 32'(cmd_len_q) - 32'd1;
  assign last       = (beats_next == 32'd0);
  // A new buffer is chosen whenever the FSM is about to enter LOAD.
  assign sel_load   = ((state_q == StIdle) && frame_start) ||
                      ((state_q == StIssue) && hs && (restart_pend_q || frame_start));

  rd_buf_sel #(
    .BUF_NUM   (BUF_NUM),
    .BUF_IDX_W (BUF_IDX_W)
  ) u_buf_sel (
    .clk         (clk),
    .rst         (rst),
    .load        (sel_load),
    .wr_buf_idx  (wr_buf_idx),
    .cur_buf_idx (cur_buf_idx)
  );

  always_comb begin
    state_d        = state_q;
    beats_left_d   = beats_left_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_len_d      = cmd_len_q;
    busy_d         = busy_q;
    frame_done_d   = 1'b0;
    restart_pend_d = restart_pend_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d      = StLoad;
          busy_d       = 1'b1;
          beats_left_d = BEAT_W'(FRAME_BEATS);
        end
      end
      StLoad: begin
        cmd_addr_d  = buf_base(cur_buf_idx, BASE_ADDR, BUF_STRIDE);
        cmd_len_d   = len_of(beats_left_q);
        cmd_valid_d = 1'b1;
        state_d     = StIssue;
        if (frame_start) restart_pend_d = 1'b1;
      end
      StIssue: begin
        if (hs) begin
          if (restart_pend_q || (frame_start && !last)) begin
            // Abandon the rest of this frame silently and restart on a fresh buffer.
            cmd_valid_d    = 1'b0;
            state_d        = StLoad;
            beats_left_d   = BEAT_W'(FRAME_BEATS);
            restart_pend_d = 1'b0;
          end else if (last) begin
            cmd_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            beats_left_d = '0;
            if (frame_start) begin
              state_d      = StLoad;
              beats_left_d = BEAT_W'(FRAME_BEATS);
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else begin
            beats_left_d = BEAT_W'(beats_next);
            cmd_addr_d   = cmd_addr_q + ADDR_WIDTH'((32'(cmd_len_q) + 32'd1) * BEAT_BYTES);
            cmd_len_d    = len_of(BEAT_W'(beats_next));
          end
        end else if (frame_start) begin
          restart_pend_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      beats_left_q   <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_len_q      <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beats_left_q   <= beats_left_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_len_q      <= cmd_len_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_len    = cmd_len_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rd_frame_addr_gen.sv
// Directed bench for rd_frame_addr_gen with a command scoreboard checked on every handshake.
module tb_rd_frame_addr_gen;

  localparam int unsigned FB = 200;
  localparam int unsigned BL = 64;

  typedef struct packed {
    logic [27:0] addr;
    logic [7:0]  len;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr_buf_idx = 2'd0;
  logic        frame_start = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [27:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  cur_buf_idx;
  logic        busy;
  logic        frame_done;

  int   vectors = 0;
  int   miscompares = 0;
  cmd_t exp_q[$];
  cmd_t mon_e;

  always #5 clk = ~clk;

  rd_frame_addr_gen #(
    .ADDR_WIDTH  (28),
    .BUF_NUM     (3),
    .BUF_IDX_W   (2),
    .BASE_ADDR   (28'h000_0000),
    .BUF_STRIDE  (28'h080_0000),
    .FRAME_BEATS (FB),
    .BURST_LEN   (BL),
    .BEAT_BYTES  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_buf_idx  (wr_buf_idx),
    .frame_start (frame_start),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cur_buf_idx (cur_buf_idx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the first n commands of a frame read from buffer idx.
  task automatic push_frame(input int idx, input int n);
    int unsigned rem, off, l;
    rem = FB;
    off = 0;
    for (int i = 0; i < n && rem > 0; i++) begin
      l = (rem > BL) ? BL : rem;
      exp_q.push_back('{addr: 28'(idx * 32'h80_0000 + off * 32), len: 8'(l - 1)});
      off += l;
      rem -= l;
    end
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = frame_done;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        check("cmd_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_addr", 32'(cmd_addr), 32'(mon_e.addr));
        check("cmd_len", 32'(cmd_len), 32'(mon_e.len));
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_addr", 32'(cmd_addr), 32'd0);
    check("rst_len", 32'(cmd_len), 32'd0);
    check("rst_cur", 32'(cur_buf_idx), 32'd2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    tick();

    // Scenario 1: full frame with ready held high, exact timing
    wr_buf_idx = 2'd1; cmd_ready = 1'b1; frame_start = 1'b1;
    push_frame(0, 4);
    tick();
    frame_start = 1'b0;
    check("s1_valid_c1", 32'(cmd_valid), 32'd0);
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_cur", 32'(cur_buf_idx), 32'd0);
    tick();
    check("s1_valid_c2", 32'(cmd_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s1_no_done", 32'(frame_done), 32'd0);
    end
    tick();
    check("s1_done", 32'(frame_done), 32'd1);
    check("s1_valid_off", 32'(cmd_valid), 32'd0);
    check("s1_busy_off", 32'(busy), 32'd0);
    tick();
    check("s1_done_pulse", 32'(frame_done), 32'd0);
    check("s1_q_empty", 32'(exp_q.size()), 32'd0);

    // Scenario 2: write index 0 wraps to buffer 2, then an invalid index holds the selection
    wr_buf_idx = 2'd0; frame_start = 1'b1;
    push_frame(2, 4);
    tick();
    frame_start = 1'b0;
    check("s2_cur_wrap", 32'(cur_buf_idx), 32'd2);
    wait_done("s2_done_a");
    wr_buf_idx = 2'd3; frame_start = 1'b1;
    push_frame(2, 4);
    tick();
    frame_start = 1'b0;
    check("s2_cur_hold", 32'(cur_buf_idx), 32'd2);
    wait_done("s2_done_b");
    tick();

    // Scenario 3: back-pressure on the second command
    wr_buf_idx = 2'd1; frame_start = 1'b1;
    push_frame(0, 4);
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("s3_stall_valid", 32'(cmd_valid), 32'd1);
      check("s3_stall_addr", 32'(cmd_addr), 32'h800);
      check("s3_stall_len", 32'(cmd_len), 32'd63);
      tick();
    end
    cmd_ready = 1'b1;
    wait_done("s3_done");
    check("s3_q_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Scenario 4: restart requested during a stalled third command
    wr_buf_idx = 2'd1; frame_start = 1'b1;
    push_frame(0, 3);
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    tick();
    check("s4_third_addr", 32'(cmd_addr), 32'h1000);
    cmd_ready = 1'b0; frame_start = 1'b1; wr_buf_idx = 2'd2;
    tick();
    frame_start = 1'b0;
    tick();
    check("s4_stall_valid", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    push_frame(1, 4);
    tick();
    check("s4_drop_valid", 32'(cmd_valid), 32'd0);
    check("s4_no_done", 32'(frame_done), 32'd0);
    check("s4_busy", 32'(busy), 32'd1);
    check("s4_cur", 32'(cur_buf_idx), 32'd1);
    tick();
    check("s4_new_valid", 32'(cmd_valid), 32'd1);
    check("s4_new_addr", 32'(cmd_addr), 32'h080_0000);
    check("s4_new_len", 32'(cmd_len), 32'd63);
    wait_done("s4_done");
    check("s4_q_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Scenario 5: reset while a command is stalled
    wr_buf_idx = 2'd1; cmd_ready = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("s5_valid_pre", 32'(cmd_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_valid", 32'(cmd_valid), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_cur", 32'(cur_buf_idx), 32'd2);
    check("s5_addr", 32'(cmd_addr), 32'd0);
    cmd_ready = 1'b1; frame_start = 1'b1;
    push_frame(0, 4);
    tick();
    frame_start = 1'b0;
    tick();
    check("s5_restart_valid", 32'(cmd_valid), 32'd1);
    wait_done("s5_done");
    tick();

    // Scenario 6: frame start coincident with the final handshake
    wr_buf_idx = 2'd1; frame_start = 1'b1;
    push_frame(0, 4);
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("s6_last_len", 32'(cmd_len), 32'd7);
    frame_start = 1'b1; wr_buf_idx = 2'd0;
    push_frame(2, 4);
    tick();
    frame_start = 1'b0;
    check("s6_done", 32'(frame_done), 32'd1);
    check("s6_valid_off", 32'(cmd_valid), 32'd0);
    check("s6_busy", 32'(busy), 32'd1);
    check("s6_cur", 32'(cur_buf_idx), 32'd2);
    tick();
    check("s6_valid_on", 32'(cmd_valid), 32'd1);
    check("s6_addr", 32'(cmd_addr), 32'h100_0000);
    check("s6_done_pulse", 32'(frame_done), 32'd0);
    wait_done("s6_done_b");
    tick();
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
